// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Generates datapath strobes, flags undecodable instructions and counts
// retired instructions. Outputs are Moore-decoded from the state and the
// opcode/funct latched on DECODE exit. Exceptions: FETCH/EXEC strobes are
// qualified by mem_ready/zero, and DECODE uses the live opcode for the jump.
module mc_ctrl #(
   parameter int OP_W         = 6,
   parameter int FUNCT_W      = 6,
   parameter int ALUOP_W      = 3,
   parameter int CNT_W        = 16,
   parameter bit STRICT_FUNCT = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               alu_src,
   output logic               ext_op,
   output logic [ALUOP_W-1:0] aluop,
   output logic               illegal,
   output logic [CNT_W-1:0]   instr_cnt,
   output logic [2:0]         state
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   localparam logic [OP_W-1:0] OP_R     = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b001001);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

   localparam logic [FUNCT_W-1:0] FN_ADD  = FUNCT_W'(6'b100000);
   localparam logic [FUNCT_W-1:0] FN_ADDU = FUNCT_W'(6'b100001);
   localparam logic [FUNCT_W-1:0] FN_SUBU = FUNCT_W'(6'b100011);
   localparam logic [FUNCT_W-1:0] FN_AND  = FUNCT_W'(6'b100100);
   localparam logic [FUNCT_W-1:0] FN_OR   = FUNCT_W'(6'b100101);
   localparam logic [FUNCT_W-1:0] FN_SLT  = FUNCT_W'(6'b101010);

   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

   logic [OP_W-1:0]    op_q;
   logic [FUNCT_W-1:0] funct_q;
   logic [2:0]         state_next;
   logic               illegal_next;
   logic               load_q;
   logic               cnt_inc;

   // True for every opcode the sequencer knows how to run.
   function automatic logic op_known(input logic [OP_W-1:0] o);
      return (o == OP_R) || (o == OP_ADDIU) || (o == OP_ORI) || (o == OP_LW) ||
             (o == OP_SW) || (o == OP_BEQ) || (o == OP_J);
   endfunction

   // True for every R-type funct with a dedicated ALU operation.
   function automatic logic funct_known(input logic [FUNCT_W-1:0] f);
      return (f == FN_ADD) || (f == FN_ADDU) || (f == FN_SUBU) ||
             (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
   endfunction

   // R-type funct to ALU op; anything unrecognised falls back to ADD,
   // which is what the lenient mode relies on.
   function automatic logic [ALUOP_W-1:0] funct_alu(input logic [FUNCT_W-1:0] f);
      logic [ALUOP_W-1:0] a;
      a = ALU_ADD;
      if (f == FN_SUBU) a = ALU_SUB;
      if (f == FN_AND)  a = ALU_AND;
      if (f == FN_OR)   a = ALU_OR;
      if (f == FN_SLT)  a = ALU_SLT;
      return a;
   endfunction

   // Next-state and strobe decode for the current state.
   always_comb begin
      state_next   = state;
      illegal_next = 1'b0;
      load_q       = 1'b0;
      cnt_inc      = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      alu_src      = 1'b0;
      ext_op       = 1'b0;
      aluop        = ALU_ADD;
      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            load_q = 1'b1;
            if (!op_known(op) || (STRICT_FUNCT && (op == OP_R) && !funct_known(funct))) begin
               illegal_next = 1'b1;
               state_next   = S_FETCH;
            end else if (op == OP_J) begin
               // Jump retires here: the target is ready straight from the IR.
               pc_write   = 1'b1;
               pc_src     = 2'b10;
               cnt_inc    = 1'b1;
               state_next = S_FETCH;
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_R: begin
                  aluop      = funct_alu(funct_q);
                  state_next = S_WB;
               end
               OP_ADDIU: begin
                  alu_src    = 1'b1;
                  ext_op     = 1'b1;
                  state_next = S_WB;
               end
               OP_ORI: begin
                  aluop      = ALU_OR;
                  alu_src    = 1'b1;
                  state_next = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_src    = 1'b1;
                  ext_op     = 1'b1;
                  state_next = S_MEM;
               end
               OP_BEQ: begin
                  aluop      = ALU_SUB;
                  pc_src     = 2'b01;
                  pc_write   = zero;
                  cnt_inc    = 1'b1;
                  state_next = S_FETCH;
               end
               default: state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            // Only lw and sw reach MEM; the strobe holds until memory answers.
            if (op_q == OP_LW) mem_read = 1'b1;
            else               mem_write = 1'b1;
            if (mem_ready) begin
               if (op_q == OP_LW) begin
                  state_next = S_WB;
               end else begin
                  cnt_inc    = 1'b1;
                  state_next = S_FETCH;
               end
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op_q == OP_R);
            mem_to_reg = (op_q == OP_LW);
            cnt_inc    = 1'b1;
            state_next = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // State, latched instruction fields, illegal pulse and retire counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         op_q      <= '0;
         funct_q   <= '0;
         illegal   <= 1'b0;
         instr_cnt <= '0;
      end else begin
         state   <= state_next;
         illegal <= illegal_next;
         if (load_q) begin
            op_q    <= op;
            funct_q <= funct;
         end
         if (cnt_inc) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven check of mc_ctrl, plus short hand-written
// sequences for lenient funct mode and a narrow wrapping counter.
module tb_mc_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, rst1_n, rst2_n;
   logic [5:0] op, funct;
   logic       zero, mem_ready;

   // DUT0: strict funct, 16-bit counter
   logic ir_write0, pc_write0, mem_read0, mem_write0, reg_write0, reg_dst0;
   logic mem_to_reg0, alu_src0, ext_op0, illegal0;
   logic [1:0] pc_src0; logic [2:0] aluop0, state0; logic [15:0] instr_cnt0;
   // DUT1: lenient funct
   logic ir_write1, pc_write1, mem_read1, mem_write1, reg_write1, reg_dst1;
   logic mem_to_reg1, alu_src1, ext_op1, illegal1;
   logic [1:0] pc_src1; logic [2:0] aluop1, state1; logic [15:0] instr_cnt1;
   // DUT2: 2-bit counter
   logic ir_write2, pc_write2, mem_read2, mem_write2, reg_write2, reg_dst2;
   logic mem_to_reg2, alu_src2, ext_op2, illegal2;
   logic [1:0] pc_src2; logic [2:0] aluop2, state2; logic [1:0] instr_cnt2;

   mc_ctrl #(.STRICT_FUNCT(1'b1), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .ir_write(ir_write0), .pc_write(pc_write0), .pc_src(pc_src0), .mem_read(mem_read0),
      .mem_write(mem_write0), .reg_write(reg_write0), .reg_dst(reg_dst0),
      .mem_to_reg(mem_to_reg0), .alu_src(alu_src0), .ext_op(ext_op0), .aluop(aluop0),
      .illegal(illegal0), .instr_cnt(instr_cnt0), .state(state0));

   mc_ctrl #(.STRICT_FUNCT(1'b0), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst1_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .ir_write(ir_write1), .pc_write(pc_write1), .pc_src(pc_src1), .mem_read(mem_read1),
      .mem_write(mem_write1), .reg_write(reg_write1), .reg_dst(reg_dst1),
      .mem_to_reg(mem_to_reg1), .alu_src(alu_src1), .ext_op(ext_op1), .aluop(aluop1),
      .illegal(illegal1), .instr_cnt(instr_cnt1), .state(state1));

   mc_ctrl #(.STRICT_FUNCT(1'b1), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .ir_write(ir_write2), .pc_write(pc_write2), .pc_src(pc_src2), .mem_read(mem_read2),
      .mem_write(mem_write2), .reg_write(reg_write2), .reg_dst(reg_dst2),
      .mem_to_reg(mem_to_reg2), .alu_src(alu_src2), .ext_op(ext_op2), .aluop(aluop2),
      .illegal(illegal2), .instr_cnt(instr_cnt2), .state(state2));

   // Packed strobe view: ir,pw,ps[1:0],mr,mw,rw,rd,m2r,as,eo,aluop[2:0],ill
   logic [14:0] act0;
   assign act0 = {ir_write0, pc_write0, pc_src0, mem_read0, mem_write0, reg_write0,
                  reg_dst0, mem_to_reg0, alu_src0, ext_op0, aluop0, illegal0};

   localparam logic [5:0] R = 6'b000000, ADDIU = 6'b001001, ORI = 6'b001101,
                          LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                          J = 6'b000010, BAD = 6'b111111;
   localparam logic [5:0] ADDU = 6'b100001, SUBU = 6'b100011, F0 = 6'b000000;

   typedef struct {
      logic        rst_n;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        rdy;
      logic [2:0]  st;
      logic [14:0] ctrl;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [14:0] c(input logic ir, pw, input logic [1:0] ps,
                                     input logic mr, mw, rw, rd, m2r, as_, eo,
                                     input logic [2:0] aop, input logic ill);
      return {ir, pw, ps, mr, mw, rw, rd, m2r, as_, eo, aop, ill};
   endfunction

   task automatic push(input logic r, input logic [5:0] o, f, input logic z, rdy,
                       input logic [2:0] st, input logic [14:0] ctl, input logic [15:0] cnt);
      vec_t v;
      v.rst_n = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rdy;
      v.st = st; v.ctrl = ctl; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic step(input logic [5:0] o, f, input logic rdy);
      @(negedge clk);
      op = o; funct = f; mem_ready = rdy; zero = 1'b0;
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   logic [14:0] FW, FG, NO, FWI, EX_LS;
   logic [1:0]  exp_cnt2 [6];

   initial begin
      rst_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
      op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

      FW    = c(0,0,2'b00,1,0,0,0,0,0,0,3'd0,0);  // FETCH waiting
      FG    = c(1,1,2'b00,1,0,0,0,0,0,0,3'd0,0);  // FETCH with mem_ready
      NO    = c(0,0,2'b00,0,0,0,0,0,0,0,3'd0,0);  // no strobes
      FWI   = c(0,0,2'b00,1,0,0,0,0,0,0,3'd0,1);  // FETCH waiting, illegal pulse
      EX_LS = c(0,0,2'b00,0,0,0,0,0,1,1,3'd0,0);  // ADD, sign-extended immediate

      // rst z  op   funct zero rdy  state ctrl  cnt
      push(0, R,   F0,   0, 0, 3'd0, FW, 0);                                 // reset
      // addu
      push(1, R,   ADDU, 0, 1, 3'd0, FG, 0);
      push(1, R,   ADDU, 0, 1, 3'd1, NO, 0);
      push(1, R,   ADDU, 0, 1, 3'd2, NO, 0);                                 // aluop ADD, rt
      push(1, R,   ADDU, 0, 1, 3'd4, c(0,0,0,0,0,1,1,0,0,0,3'd0,0), 0);
      // lw with 3 fetch waits and 2 mem waits: 10 cycles
      push(1, LW,  F0,   0, 0, 3'd0, FW, 1);
      push(1, LW,  F0,   0, 0, 3'd0, FW, 1);
      push(1, LW,  F0,   0, 0, 3'd0, FW, 1);
      push(1, LW,  F0,   0, 1, 3'd0, FG, 1);
      push(1, LW,  F0,   0, 1, 3'd1, NO, 1);
      push(1, LW,  F0,   0, 1, 3'd2, EX_LS, 1);
      push(1, LW,  F0,   0, 0, 3'd3, c(0,0,0,1,0,0,0,0,0,0,3'd0,0), 1);
      push(1, LW,  F0,   0, 0, 3'd3, c(0,0,0,1,0,0,0,0,0,0,3'd0,0), 1);
      push(1, LW,  F0,   0, 1, 3'd3, c(0,0,0,1,0,0,0,0,0,0,3'd0,0), 1);
      push(1, LW,  F0,   0, 1, 3'd4, c(0,0,0,0,0,1,0,1,0,0,3'd0,0), 1);
      // beq taken
      push(1, BEQ, F0,   0, 1, 3'd0, FG, 2);
      push(1, BEQ, F0,   0, 1, 3'd1, NO, 2);
      push(1, BEQ, F0,   1, 1, 3'd2, c(0,1,2'b01,0,0,0,0,0,0,0,3'd1,0), 2);
      // beq not taken
      push(1, BEQ, F0,   0, 1, 3'd0, FG, 3);
      push(1, BEQ, F0,   0, 1, 3'd1, NO, 3);
      push(1, BEQ, F0,   0, 1, 3'd2, c(0,0,2'b01,0,0,0,0,0,0,0,3'd1,0), 3);
      // R-type with unknown funct in strict mode
      push(1, R,   F0,   0, 1, 3'd0, FG, 4);
      push(1, R,   F0,   0, 1, 3'd1, NO, 4);
      push(1, R,   F0,   0, 0, 3'd0, FWI, 4);
      push(1, R,   F0,   0, 0, 3'd0, FW, 4);
      // unknown opcode
      push(1, BAD, F0,   0, 1, 3'd0, FG, 4);
      push(1, BAD, F0,   0, 1, 3'd1, NO, 4);
      push(1, BAD, F0,   0, 0, 3'd0, FWI, 4);
      // addiu
      push(1, ADDIU, F0, 0, 1, 3'd0, FG, 4);
      push(1, ADDIU, F0, 0, 1, 3'd1, NO, 4);
      push(1, ADDIU, F0, 0, 1, 3'd2, EX_LS, 4);
      push(1, ADDIU, F0, 0, 1, 3'd4, c(0,0,0,0,0,1,0,0,0,0,3'd0,0), 4);
      // ori
      push(1, ORI, F0,   0, 1, 3'd0, FG, 5);
      push(1, ORI, F0,   0, 1, 3'd1, NO, 5);
      push(1, ORI, F0,   0, 1, 3'd2, c(0,0,0,0,0,0,0,0,1,0,3'd3,0), 5);
      push(1, ORI, F0,   0, 1, 3'd4, c(0,0,0,0,0,1,0,0,0,0,3'd0,0), 5);
      // sw, no wait
      push(1, SW,  F0,   0, 1, 3'd0, FG, 6);
      push(1, SW,  F0,   0, 1, 3'd1, NO, 6);
      push(1, SW,  F0,   0, 1, 3'd2, EX_LS, 6);
      push(1, SW,  F0,   0, 1, 3'd3, c(0,0,0,0,1,0,0,0,0,0,3'd0,0), 6);
      // j
      push(1, J,   F0,   0, 1, 3'd0, FG, 7);
      push(1, J,   F0,   0, 1, 3'd1, c(0,1,2'b10,0,0,0,0,0,0,0,3'd0,0), 7);
      // subu; op/funct scrambled after DECODE must not matter
      push(1, R,   SUBU, 0, 1, 3'd0, FG, 8);
      push(1, R,   SUBU, 0, 1, 3'd1, NO, 8);
      push(1, BAD, F0,   0, 1, 3'd2, c(0,0,0,0,0,0,0,0,0,0,3'd1,0), 8);
      push(1, BAD, F0,   0, 1, 3'd4, c(0,0,0,0,0,1,1,0,0,0,3'd0,0), 8);
      // sw interrupted by reset in MEM
      push(1, SW,  F0,   0, 1, 3'd0, FG, 9);
      push(1, SW,  F0,   0, 1, 3'd1, NO, 9);
      push(1, SW,  F0,   0, 1, 3'd2, EX_LS, 9);
      push(1, SW,  F0,   0, 0, 3'd3, c(0,0,0,0,1,0,0,0,0,0,3'd0,0), 9);
      push(0, SW,  F0,   0, 0, 3'd0, FW, 0);
      push(1, SW,  F0,   0, 0, 3'd0, FW, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_n = vecs[i].rst_n; op = vecs[i].op; funct = vecs[i].funct;
         zero = vecs[i].zero; mem_ready = vecs[i].rdy;
         #1;
         n_vec++;
         if (state0 !== vecs[i].st || act0 !== vecs[i].ctrl || instr_cnt0 !== vecs[i].cnt) begin
            n_bad++;
            $display("FAIL vec%0d: got state=%0d ctrl=%h cnt=%0d, expected state=%0d ctrl=%h cnt=%0d",
                     i, state0, act0, instr_cnt0, vecs[i].st, vecs[i].ctrl, vecs[i].cnt);
         end else begin
            $display("ok   vec%0d state=%0d ctrl=%h cnt=%0d", i, state0, act0, instr_cnt0);
         end
      end

      // Lenient funct: funct 000000 runs as ADD and writes rd.
      rst_n = 1'b0;
      step(R, F0, 1'b1); rst1_n = 1'b1; #1;
      check("len_fetch_state", 16'(state1), 16'd0);
      step(R, F0, 1'b1);
      check("len_decode_state", 16'(state1), 16'd1);
      step(R, F0, 1'b1);
      check("len_exec_state", 16'(state1), 16'd2);
      check("len_exec_aluop", 16'(aluop1), 16'd0);
      step(R, F0, 1'b1);
      check("len_wb_regwrite", 16'({state1, reg_write1, reg_dst1}), 16'({3'd4, 1'b1, 1'b1}));
      step(R, F0, 1'b0);
      check("len_cnt_illegal", 16'({instr_cnt1[3:0], illegal1}), 16'({4'd1, 1'b0}));

      // 2-bit counter wraps across five jumps: 1,2,3,0,1.
      exp_cnt2[0] = 2'd0; exp_cnt2[1] = 2'd1; exp_cnt2[2] = 2'd2;
      exp_cnt2[3] = 2'd3; exp_cnt2[4] = 2'd0; exp_cnt2[5] = 2'd1;
      step(J, F0, 1'b1); rst2_n = 1'b1; #1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step(J, F0, 1'b1);
         check($sformatf("wrap_cnt%0d", k), 16'(instr_cnt2), 16'(exp_cnt2[k]));
         step(J, F0, 1'b1);
         check($sformatf("wrap_jump%0d", k), 16'({state2, pc_write2, pc_src2}),
               16'({3'd1, 1'b1, 2'b10}));
      end
      step(J, F0, 1'b0);
      check("wrap_cnt_final", 16'(instr_cnt2), 16'(exp_cnt2[5]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle successor to the single-cycle R-type control decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a memory wait handshake, and drives datapath strobes. It adds I-type, lw, sw, beq and j support, a strict/lenient funct mode, an illegal-instruction flag and a retired-instruction counter. It sits between the instruction register and the shared multi-cycle datapath.

Parameters:
OP_W, 6, opcode width
FUNCT_W, 6, funct width
ALUOP_W, 3, ALU op code width
CNT_W, 16, retired-instruction counter width
STRICT_FUNCT, 1, 1 = unknown R-type funct is illegal; 0 = unknown funct executes as ADD

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  OP_W  opcode from instruction register
funct  in  FUNCT_W  funct field from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
ir_write  out  1  load instruction register
pc_write  out  1  load PC
pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register-file write enable
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = memory data, 0 = ALU result
alu_src  out  1  1 = extended immediate, 0 = rt
ext_op  out  1  1 = sign extend, 0 = zero extend
aluop  out  ALUOP_W  ADD=0, SUB=1, AND=2, OR=3, SLT=4
illegal  out  1  one-cycle pulse on an undecodable instruction
instr_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4

Behaviour:
- Reset (rst_n low, asynchronous): state=FETCH, instr_cnt=0, op_q/funct_q=0, illegal=0. Outputs then take the FETCH decode.
- Outputs are Moore-decoded from state plus the latched op_q/funct_q; the only exceptions are the zero/mem_ready-qualified strobes noted below. Any strobe not listed for a state is 0. Default aluop is ADD, pc_src 00.
- Opcodes: R=000000, addiu=001001, ori=001101, lw=100011, sw=101011, beq=000100, j=000010.
- Functs: addu=100001 and add=100000 map to ADD; subu=100011 to SUB; and=100100 to AND; or=100101 to OR; slt=101010 to SLT.
- FETCH: mem_read=1. ir_write and pc_write (pc_src 00) are asserted only while mem_ready=1; the FSM then goes to DECODE. Otherwise it stays in FETCH indefinitely.
- DECODE: op_q/funct_q load from op/funct on exit.
  - Unknown opcode, or R-type with unknown funct when STRICT_FUNCT=1: illegal pulses for the cycle after DECODE; the FSM goes to FETCH and instr_cnt does not increment.
  - j: pc_write=1, pc_src=10, go to FETCH, instr_cnt increments.
  - Otherwise go to EXEC.
- EXEC:
  - R: aluop from funct_q, alu_src=0, go to WB.
  - addiu: ADD, alu_src=1, ext_op=1, go to WB.
  - ori: OR, alu_src=1, ext_op=0, go to WB.
  - lw/sw: ADD, alu_src=1, ext_op=1, go to MEM.
  - beq: SUB, alu_src=0, pc_src=01, pc_write=zero, go to FETCH, instr_cnt increments.
- MEM: lw asserts mem_read; sw asserts mem_write. The strobe is held until mem_ready=1. On mem_ready, lw goes to WB; sw goes to FETCH and instr_cnt increments.
- WB: reg_write=1; reg_dst=1 only for R; mem_to_reg=1 only for lw. Go to FETCH, instr_cnt increments.
- Latency per instruction, with zero memory wait: j=2 cycles, beq=3, sw=4, R/I=4, lw=5. Each cycle with mem_ready low adds one cycle.
- instr_cnt wraps from all-ones to 0 without a flag.
- rst_n asserted mid-instruction: immediate return to FETCH, no partial write strobes after reset, counter cleared.
- op/funct changes outside DECODE have no effect.

Test Plan:
- Reset then addu (op 000000, funct 100001), mem_ready=1 → states 0,1,2,4,0; aluop=0 in EXEC; reg_write=1 and reg_dst=1 in WB; instr_cnt=1.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM → mem_read held through the waits; total 10 cycles; mem_to_reg=1 in WB.
- beq with zero=1, then beq with zero=0 → pc_write=1 with pc_src=01 in the first EXEC, pc_write=0 in the second; instr_cnt +2.
- R-type funct 000000: with STRICT_FUNCT=1, illegal pulses once and no reg_write; with STRICT_FUNCT=0, executes as ADD with reg_write=1.
- Unknown opcode 111111 → illegal pulse, FSM returns to FETCH, instr_cnt unchanged.
- CNT_W=2, five j instructions → instr_cnt sequence 1,2,3,0,1; rst_n low during MEM of a sw → mem_write drops immediately, state=0, instr_cnt=0.
